vga_fb_fill_arbiter: RTL
========================

# vga_fb_fill_arbiter

Write-port controller for the 2k x 8 VGA framebuffer (40x30 cells, address {row[4:0], col[5:0]}). It shares the single framebuffer write port between MCU stores and a hardware rectangle-fill engine, which clears or paints screen regions without CPU loops. It sits between the MCU I/O bus and the framebuffer write inputs (WA/WD/WE). The read port and VGA scan-out path do not pass through it.

## Interface
- COLS, 40, visible columns
- ROWS, 30, visible rows
- CLK  in  1  system clock, 50 MHz
- RST  in  1  reset; asynchronous, active-high
- CPU_WE  in  1  MCU write strobe, single cycle, always accepted
- CPU_WA  in  11  MCU write address
- CPU_WD  in  8  MCU write data (RRRGGGBB)
- FILL_START  in  1  start-fill strobe; ignored while FILL_BUSY=1
- FILL_X0, FILL_X1  in  6  column bounds, inclusive
- FILL_Y0, FILL_Y1  in  5  row bounds, inclusive
- FILL_COLOR  in  8  fill data
- FILL_BUSY  out  1  fill in progress (CHECK or RUN)
- FILL_DONE  out  1  one-cycle pulse, fill complete
- FILL_ERR  out  1  one-cycle pulse, fill rejected
- FB_WE, FB_WA[10:0], FB_WD[7:0]  out  to framebuffer write port, registered

## Operation
- FSM states: IDLE, CHECK, RUN, DONE, ERR. FILL_BUSY=1 in CHECK/RUN. FILL_DONE=1 only in DONE. FILL_ERR=1 only in ERR.
- IDLE: when FILL_START=1, latch X0/X1/Y0/Y1/COLOR and go to CHECK.
- CHECK, one cycle: reject on X0>X1, Y0>Y1, X0>=COLS or Y0>=ROWS, and go to ERR. X1/Y1 out of range is handled per Configuration. Otherwise load cursor (x,y)=(X0,Y0) and go to RUN.
- RUN: in each cycle with CPU_WE=0, issue a fill write at {y,x} with COLOR. If x==X1, set x=X0 and y=y+1; otherwise x=x+1. The write at (X1,Y1) moves the FSM to DONE. In a cycle with CPU_WE=1, the CPU write is issued and the cursor holds.
- DONE and ERR each last one cycle, then return to IDLE.
- Arbitration is fixed priority to the CPU. The MCU is never stalled. Fill throughput is one pixel per cycle without CPU writes.
- Every fill pixel is written exactly once. A CPU write to a pixel inside the rectangle is ordered by issue cycle: the later write wins.
- CPU_WE is passed through in every state, including IDLE, CHECK, DONE and ERR.
- Arithmetic: x is 6 bits, y is 5 bits, and neither ever exceeds the latched bound, so no wrap occurs.

## Timing
- Reset values: FB_WE=0, FB_WA=0, FB_WD=0, FILL_BUSY=0, FILL_DONE=0, FILL_ERR=0, state IDLE, cursor 0.
- RST asserted mid-fill aborts immediately. The fill does not resume and no DONE or ERR pulse is produced.
- CPU path latency is 1 cycle: CPU_WE/WA/WD sampled at edge k appear on FB_* after edge k.
- Fill write latency is 1 cycle after its RUN cycle. The last fill FB_WE coincides with FILL_DONE.
- For an N-pixel fill with no contention, FILL_DONE is high N+2 cycles after the FILL_START sampling edge. Each CPU_WE during RUN adds 1 cycle.
- FILL_ERR is high 2 cycles after the FILL_START sampling edge. No fill FB_WE is issued for a rejected fill.
- FILL_START and CPU_WE in the same cycle are both accepted.
- FILL_START during DONE/ERR is ignored. It is accepted again from IDLE.

## Configuration
- FB_FILL_CLIP_EN defined: X1>=COLS is clamped to COLS-1 and Y1>=ROWS to ROWS-1 in CHECK. The fill proceeds on the clipped rectangle.
- FB_FILL_CLIP_EN undefined: X1>=COLS or Y1>=ROWS results in ERR.
- All other behaviour is identical with and without the macro.

## Structure
- Package vga_fb_pkg holds:
  - COLS, ROWS
  - fb_addr_t (11-bit), fb_color_t (8-bit)
  - the fill state enum
  - function fb_addr(row,col) returning {row[4:0],col[5:0]}
- One sub-module, vga_fb_rect_walker, holds the x/y cursor with load, advance-enable and last-pixel flag. The FSM and arbiter mux stay in the top module.

## Test plan
- Reset: assert RST 5 cycles into a 40x30 fill -> FB_WE=0, FILL_BUSY=0 within the same cycle. No DONE after release.
- Passthrough: CPU_WE=1, CPU_WA=0x123, CPU_WD=0xE0 in IDLE -> next cycle FB_WE=1, FB_WA=0x123, FB_WD=0xE0.
- Small fill (2,1)-(4,2), COLOR=0x1C, no CPU traffic -> 6 writes: 0x042, 0x043, 0x044, 0x082, 0x083, 0x084. FILL_DONE 8 cycles after START, coinciding with the 0x084 write.
- Contention: same fill with CPU_WE held 3 cycles mid-RUN -> CPU writes appear in those 3 cycles. All 6 fill addresses are still written exactly once. FILL_DONE arrives at cycle 11.
- Errors: X0=5, X1=3 -> FILL_ERR at cycle 2, no FB_WE. X1=45 with FB_FILL_CLIP_EN -> fill clipped to column 39. Without the macro, X1=45 -> FILL_ERR.
- Full screen (0,0)-(39,29) -> 1200 writes, the last at 0x767. FILL_DONE at cycle 1202.

Source files
------------

// File: rtl/vga_fb_pkg.sv
// Shared types, screen geometry and address helper for the framebuffer
// write-port controller and its rectangle-fill engine.
package vga_fb_pkg;

  localparam int COLS = 40;
  localparam int ROWS = 30;

  typedef logic [10:0] fb_addr_t;
  typedef logic [7:0]  fb_color_t;
  typedef logic [5:0]  fb_col_t;
  typedef logic [4:0]  fb_row_t;

  localparam fb_col_t LAST_COL = fb_col_t'(COLS - 1);
  localparam fb_row_t LAST_ROW = fb_row_t'(ROWS - 1);

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    RUN,
    DONE,
    ERR
  } fill_state_t;

  function automatic fb_addr_t fb_addr(input fb_row_t row, input fb_col_t col);
    return {row, col};
  endfunction

endpackage

// File: rtl/vga_fb_fill_arbiter_if.sv
// MCU store bus, fill-engine control and framebuffer write port bundled
// together; slave is the controller, master is whoever drives it.
interface vga_fb_fill_arbiter_if;
  import vga_fb_pkg::*;

  logic      cpu_we;
  fb_addr_t  cpu_wa;
  fb_color_t cpu_wd;

  logic      fill_start;
  fb_col_t   fill_x0;
  fb_col_t   fill_x1;
  fb_row_t   fill_y0;
  fb_row_t   fill_y1;
  fb_color_t fill_color;
  logic      fill_busy;
  logic      fill_done;
  logic      fill_err;

  logic      fb_we;
  fb_addr_t  fb_wa;
  fb_color_t fb_wd;

  modport master (
    output cpu_we, cpu_wa, cpu_wd,
    output fill_start, fill_x0, fill_x1, fill_y0, fill_y1, fill_color,
    input  fill_busy, fill_done, fill_err,
    input  fb_we, fb_wa, fb_wd
  );

  modport slave (
    input  cpu_we, cpu_wa, cpu_wd,
    input  fill_start, fill_x0, fill_x1, fill_y0, fill_y1, fill_color,
    output fill_busy, fill_done, fill_err,
    output fb_we, fb_wa, fb_wd
  );

endinterface

// File: rtl/vga_fb_rect_walker.sv
// Raster cursor over an inclusive rectangle: load to the top-left corner,
// step left-to-right then top-to-bottom, flag the bottom-right pixel.
module vga_fb_rect_walker
  import vga_fb_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    load,
  input  logic    advance,
  input  fb_col_t x0,
  input  fb_col_t x1,
  input  fb_row_t y0,
  input  fb_row_t y1,
  output fb_col_t x,
  output fb_row_t y,
  output logic    last
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge, independent of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x <= '0;
      y <= '0;
    end else if (load) begin
      x <= x0;
      y <= y0;
    end else if (advance) begin
      if (x == x1) begin
        x <= x0;
        y <= y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

  assign last = (x == x1) && (y == y1);

endmodule

// File: rtl/vga_fb_fill_arbiter.sv
// Framebuffer write-port controller: MCU stores have fixed priority over the
// rectangle-fill engine. FB_FILL_CLIP_EN clamps oversize fills instead of rejecting.
module vga_fb_fill_arbiter
  import vga_fb_pkg::*;
(
  input logic                 clk,
  input logic                 rst,
  vga_fb_fill_arbiter_if.slave bus
);

`ifdef FB_FILL_CLIP_EN
  localparam bit CLIP_EN = 1'b1;
`else
  localparam bit CLIP_EN = 1'b0;
`endif

  fill_state_t state, state_nx;

  fb_col_t   x0_q, x1_q;
  fb_row_t   y0_q, y1_q;
  fb_color_t color_q;

  fb_col_t   cur_x;
  fb_row_t   cur_y;
  logic      cur_last;
  logic      load, fill_wr, bad_rect;

  logic      fb_we_q;
  fb_addr_t  fb_wa_q;
  fb_color_t fb_wd_q;

  // Request is captured on acceptance; oversize far corners are clamped while checking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x0_q    <= '0;
      x1_q    <= '0;
      y0_q    <= '0;
      y1_q    <= '0;
      color_q <= '0;
    end else if (state == IDLE && bus.fill_start) begin
      x0_q    <= bus.fill_x0;
      x1_q    <= bus.fill_x1;
      y0_q    <= bus.fill_y0;
      y1_q    <= bus.fill_y1;
      color_q <= bus.fill_color;
    end else if (state == CHECK && CLIP_EN) begin
      if (x1_q > LAST_COL) x1_q <= LAST_COL;
      if (y1_q > LAST_ROW) y1_q <= LAST_ROW;
    end
  end

  assign bad_rect = (x0_q > x1_q) || (y0_q > y1_q) ||
                    (x0_q > LAST_COL) || (y0_q > LAST_ROW) ||
                    (!CLIP_EN && ((x1_q > LAST_COL) || (y1_q > LAST_ROW)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    fill_wr  = 1'b0;
    unique case (state)
      IDLE:  if (bus.fill_start) state_nx = CHECK;
      CHECK: begin
        if (bad_rect) begin
          state_nx = ERR;
        end else begin
          load     = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        if (!bus.cpu_we) begin
          fill_wr = 1'b1;
          if (cur_last) state_nx = DONE;
        end
      end
      DONE:    state_nx = IDLE;
      ERR:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // The cursor never steps past the last pixel, so it stays inside the bounds.
  vga_fb_rect_walker u_walker (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .advance (fill_wr && !cur_last),
    .x0      (x0_q),
    .x1      (x1_q),
    .y0      (y0_q),
    .y1      (y1_q),
    .x       (cur_x),
    .y       (cur_y),
    .last    (cur_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fb_we_q <= 1'b0;
      fb_wa_q <= '0;
      fb_wd_q <= '0;
    end else begin
      fb_we_q <= bus.cpu_we || fill_wr;
      if (bus.cpu_we) begin
        fb_wa_q <= bus.cpu_wa;
        fb_wd_q <= bus.cpu_wd;
      end else if (fill_wr) begin
        fb_wa_q <= fb_addr(cur_y, cur_x);
        fb_wd_q <= color_q;
      end
    end
  end

  assign bus.fb_we     = fb_we_q;
  assign bus.fb_wa     = fb_wa_q;
  assign bus.fb_wd     = fb_wd_q;
  assign bus.fill_busy = (state == CHECK) || (state == RUN);
  assign bus.fill_done = (state == DONE);
  assign bus.fill_err  = (state == ERR);

endmodule
